// File: rtl/icache_pkg.sv
// Shared geometry constants and FSM state encoding for the instruction-cache refill path.
package icache_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned LINE_BYTES      = 64;
  localparam int unsigned CACHE_SET       = 8;
  localparam int unsigned MEM_DATA_WIDTH  = 64;

  localparam int unsigned OFFSET_BITS     = $clog2(LINE_BYTES);
  localparam int unsigned SET_BITS        = $clog2(CACHE_SET);
  localparam int unsigned TAG_WIDTH       = ADDR_WIDTH - OFFSET_BITS - SET_BITS;
  localparam int unsigned MEM_BEATS       = LINE_BYTES * 8 / MEM_DATA_WIDTH;
  localparam int unsigned CACHELINE_WIDTH = LINE_BYTES * 8;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StReq    = 3'd1;
  localparam state_t StFill   = 3'd2;
  localparam state_t StWrite  = 3'd3;
  localparam state_t StReplay = 3'd4;

endpackage

// File: rtl/icache_line_buf.sv
// Beat-addressed line assembly buffer; presents the whole line flat, beat k at [k*WIDTH +: WIDTH].
module icache_line_buf #(
  parameter  int unsigned BEATS = 8,
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [BEATS*WIDTH-1:0] line
);

  logic [BEATS-1:0][WIDTH-1:0] beat_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q <= '0;
    end else if (wr_en) begin
      beat_q[wr_idx] <= wr_data;
    end
  end

  assign line = beat_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss handler: requests a line, assembles MEM_BEATS beats, writes it back.
// Optional critical-word bypass under ICACHE_REFILL_BYPASS_EN (assumes 64-bit beats).
module icache_refill_ctrl
  import icache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       icacheflush,
  input  logic                       miss_valid,
  input  logic [ADDR_WIDTH-1:0]      miss_pc,
  output logic                       icachestop,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [ADDR_WIDTH-1:0]      mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_rsp_data,
  output logic                       refill_valid,
  output logic [SET_BITS-1:0]        refill_set,
  output logic [TAG_WIDTH-1:0]       refill_tag,
  output logic [CACHELINE_WIDTH-1:0] refill_data,
  output logic                       byp_valid,
  output logic [31:0]                byp_inst
);

  localparam int unsigned     CNT_W     = $clog2(MEM_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MEM_BEATS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    drop_q, drop_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    beat_wr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    beat_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss_valid && !icacheflush) begin
          pc_d    = miss_pc;
          state_d = StReq;
        end
      end
      StReq: begin
        // A flush on the handshake cycle cannot cancel the issued read; drain it instead.
        if (mem_req_ready) begin
          state_d = StFill;
          cnt_d   = '0;
          drop_d  = icacheflush;
        end else if (icacheflush) begin
          state_d = StIdle;
        end
      end
      StFill: begin
        if (icacheflush) drop_d = 1'b1;
        if (mem_rsp_valid) begin
          beat_wr = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = (drop_q || icacheflush) ? StIdle : StWrite;
        end
      end
      StWrite:  state_d = StReplay;
      StReplay: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  icache_line_buf #(
    .BEATS (MEM_BEATS),
    .WIDTH (MEM_DATA_WIDTH)
  ) u_line_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (beat_wr),
    .wr_idx  (cnt_q),
    .wr_data (mem_rsp_data),
    .line    (refill_data)
  );

  assign icachestop    = (state_q != StIdle);
  assign mem_req_valid = (state_q == StReq);
  assign refill_valid  = (state_q == StWrite);
  assign mem_req_addr  = {pc_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign refill_set    = pc_q[OFFSET_BITS +: SET_BITS];
  assign refill_tag    = pc_q[ADDR_WIDTH-1 -: TAG_WIDTH];

  logic unused_pc;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic byp_hit;
  assign byp_hit   = (state_q == StFill) && mem_rsp_valid && !drop_q && !icacheflush &&
                     (cnt_q == pc_q[OFFSET_BITS-1:3]);
  assign byp_valid = byp_hit;
  assign byp_inst  = !byp_hit ? 32'h0 : (pc_q[2] ? mem_rsp_data[63:32] : mem_rsp_data[31:0]);
  assign unused_pc = ^pc_q[1:0];
`else
  assign byp_valid = 1'b0;
  assign byp_inst  = 32'h0;
  assign unused_pc = ^pc_q[OFFSET_BITS-1:0];
`endif

`ifndef SYNTHESIS
  // Memory cannot be stalled, so a beat outside FILL means it was lost.
  rsp_only_in_fill: assert property (@(posedge clk) disable iff (!rstn)
    mem_rsp_valid |-> (state_q == StFill));
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Randomized self-checking bench for icache_refill_ctrl against a line-level miss model.
`timescale 1ns/1ps
module tb_icache_refill_ctrl;
  import icache_pkg::*;

`ifdef ICACHE_REFILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic                       icacheflush = 1'b0;
  logic                       miss_valid = 1'b0;
  logic [ADDR_WIDTH-1:0]      miss_pc = '0;
  logic                       icachestop;
  logic                       mem_req_valid;
  logic                       mem_req_ready = 1'b0;
  logic [ADDR_WIDTH-1:0]      mem_req_addr;
  logic                       mem_rsp_valid = 1'b0;
  logic [MEM_DATA_WIDTH-1:0]  mem_rsp_data = '0;
  logic                       refill_valid;
  logic [SET_BITS-1:0]        refill_set;
  logic [TAG_WIDTH-1:0]       refill_tag;
  logic [CACHELINE_WIDTH-1:0] refill_data;
  logic                       byp_valid;
  logic [31:0]                byp_inst;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int byp_cnt = 0;

  icache_refill_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .icacheflush   (icacheflush),
    .miss_valid    (miss_valid),
    .miss_pc       (miss_pc),
    .icachestop    (icachestop),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .refill_valid  (refill_valid),
    .refill_set    (refill_set),
    .refill_tag    (refill_tag),
    .refill_data   (refill_data),
    .byp_valid     (byp_valid),
    .byp_inst      (byp_inst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (byp_valid === 1'b1) byp_cnt <= byp_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss: memory model with handshake delay, random beat gaps, optional flush
  // after beat flush_after (last beat => flush lands in WRITE), optional stray misses in FILL.
  task automatic do_miss(input logic [31:0] pc, input int rdy_dly, input int max_gap,
                         input int flush_after, input bit inject);
    logic [MEM_DATA_WIDTH-1:0]  beats [MEM_BEATS];
    logic [CACHELINE_WIDTH-1:0] exp_line;
    logic [31:0]                exp_inst;
    bit                         exp_byp;
    bit                         dropped;
    int                         m, gaps, gap;
    dropped = 1'b0;
    gaps    = 0;
    for (int k = 0; k < MEM_BEATS; k++) begin
      beats[k] = {$urandom, $urandom};
      exp_line[k*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = beats[k];
    end
    tick();
    miss_valid = 1'b1;
    miss_pc    = pc;
    m          = cyc;
    tick();
    miss_valid = 1'b0;
    miss_pc    = $urandom;
    for (int i = 0; i <= rdy_dly; i++) begin
      mem_req_ready = (i == rdy_dly);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1)
        begin failures++; $display("FAIL req_valid: got %b want 1", mem_req_valid); end
      checks++;
      if (mem_req_addr !== (pc & 32'hFFFF_FFC0))
        begin failures++; $display("FAIL req_addr: got %h want %h", mem_req_addr, pc & 32'hFFFF_FFC0); end
      checks++;
      if (icachestop !== 1'b1)
        begin failures++; $display("FAIL stop_in_req: got %b want 1", icachestop); end
      tick();
    end
    mem_req_ready = 1'b0;
    for (int k = 0; k < MEM_BEATS; k++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        miss_valid = inject;
        miss_pc    = $urandom;
        @(negedge clk);
        checks++;
        if ({icachestop, refill_valid, byp_valid} !== 3'b100)
          begin failures++; $display("FAIL fill_gap: got %b want 100", {icachestop, refill_valid, byp_valid}); end
        tick();
        gaps++;
      end
      miss_valid    = inject;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = beats[k];
      exp_byp  = BYP && !dropped && (k == int'(pc[5:3]));
      exp_inst = exp_byp ? (pc[2] ? beats[k][63:32] : beats[k][31:0]) : 32'h0;
      @(negedge clk);
      checks++;
      if (byp_valid !== exp_byp)
        begin failures++; $display("FAIL byp_valid beat %0d: got %b want %b", k, byp_valid, exp_byp); end
      checks++;
      if (byp_inst !== exp_inst)
        begin failures++; $display("FAIL byp_inst beat %0d: got %h want %h", k, byp_inst, exp_inst); end
      checks++;
      if ({icachestop, refill_valid} !== 2'b10)
        begin failures++; $display("FAIL fill_beat: got %b want 10", {icachestop, refill_valid}); end
      tick();
      mem_rsp_valid = 1'b0;
      miss_valid    = 1'b0;
      if (k == flush_after && k != MEM_BEATS - 1) begin
        icacheflush = 1'b1;
        miss_valid  = inject;
        @(negedge clk);
        checks++;
        if ({icachestop, refill_valid, byp_valid} !== 3'b100)
          begin failures++; $display("FAIL fill_flush: got %b want 100", {icachestop, refill_valid, byp_valid}); end
        tick();
        icacheflush = 1'b0;
        miss_valid  = 1'b0;
        dropped     = 1'b1;
      end
    end
    if (flush_after == MEM_BEATS - 1) icacheflush = 1'b1;
    @(negedge clk);
    if (dropped) begin
      checks++;
      if ({icachestop, mem_req_valid, refill_valid} !== 3'b000)
        begin failures++; $display("FAIL drop_idle: got %b want 000", {icachestop, mem_req_valid, refill_valid}); end
    end else begin
      checks++;
      if (refill_valid !== 1'b1)
        begin failures++; $display("FAIL refill_valid: got %b want 1", refill_valid); end
      checks++;
      if (cyc - m != 2 + rdy_dly + MEM_BEATS + gaps)
        begin failures++; $display("FAIL latency: got %0d want %0d", cyc - m, 2 + rdy_dly + MEM_BEATS + gaps); end
      checks++;
      if (refill_set !== SET_BITS'((pc >> OFFSET_BITS) % CACHE_SET))
        begin failures++; $display("FAIL refill_set: got %h want %h", refill_set, (pc >> 6) % 8); end
      checks++;
      if (refill_tag !== TAG_WIDTH'(pc >> (OFFSET_BITS + SET_BITS)))
        begin failures++; $display("FAIL refill_tag: got %h want %h", refill_tag, pc >> 9); end
      checks++;
      if (refill_data !== exp_line)
        begin failures++; $display("FAIL refill_data: got %h want %h", refill_data, exp_line); end
      tick();
      icacheflush = 1'b0;
      @(negedge clk);
      checks++;
      if ({icachestop, refill_valid} !== 2'b10)
        begin failures++; $display("FAIL replay: got %b want 10", {icachestop, refill_valid}); end
      tick();
      @(negedge clk);
      checks++;
      if ({icachestop, mem_req_valid, refill_valid} !== 3'b000)
        begin failures++; $display("FAIL release: got %b want 000", {icachestop, mem_req_valid, refill_valid}); end
    end
    icacheflush = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({icachestop, mem_req_valid, refill_valid, byp_valid} !== 4'b0000)
      begin failures++; $display("FAIL reset_ctl: got %b want 0000", {icachestop, mem_req_valid, refill_valid, byp_valid}); end
    checks++;
    if ({mem_req_addr, refill_set, refill_tag, byp_inst} !== '0)
      begin failures++; $display("FAIL reset_fields: got %h want 0", {mem_req_addr, refill_set, refill_tag, byp_inst}); end
    checks++;
    if (refill_data !== '0)
      begin failures++; $display("FAIL reset_data: got %h want 0", refill_data); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_miss(32'h0000_1234, 0, 0, -1, 1'b0);
    do_miss(32'h0000_1234, 5, 1, -1, 1'b0);
  endtask

  task automatic test_flush_in_fill();
    do_miss(32'h0001_0F00, 1, 1, 3, 1'b0);
    do_miss(32'h0002_07C4, 0, 1, MEM_BEATS - 1, 1'b0);
  endtask

  task automatic test_flush_in_req();
    tick();
    miss_valid = 1'b1;
    miss_pc    = 32'h0000_8040;
    tick();
    miss_valid  = 1'b0;
    icacheflush = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1)
      begin failures++; $display("FAIL req_before_flush: got %b want 1", mem_req_valid); end
    tick();
    icacheflush = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_req_valid, icachestop} !== 2'b00)
      begin failures++; $display("FAIL req_flushed: got %b want 00", {mem_req_valid, icachestop}); end
    do_miss(32'h0000_8040, 2, 0, -1, 1'b0);
  endtask

  task automatic test_flush_with_miss();
    tick();
    miss_valid  = 1'b1;
    icacheflush = 1'b1;
    miss_pc     = 32'h00AB_CDE8;
    tick();
    miss_valid  = 1'b0;
    icacheflush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_req_valid, icachestop} !== 2'b00)
        begin failures++; $display("FAIL miss_dropped: got %b want 00", {mem_req_valid, icachestop}); end
      tick();
    end
    do_miss(32'h00AB_CDE8, 1, 2, -1, 1'b1);
  endtask

  task automatic test_bypass();
    int b0;
    b0 = byp_cnt;
    do_miss(32'h0000_1234, 0, 0, -1, 1'b0);
    checks++;
    if (byp_cnt - b0 != (BYP ? 1 : 0))
      begin failures++; $display("FAIL byp_pulses: got %0d want %0d", byp_cnt - b0, BYP ? 1 : 0); end
    b0 = byp_cnt;
    do_miss(32'h0000_1234, 0, 0, 2, 1'b0);
    checks++;
    if (byp_cnt - b0 != 0)
      begin failures++; $display("FAIL byp_after_drop: got %0d want 0", byp_cnt - b0); end
  endtask

  task automatic test_async_reset();
    tick();
    miss_valid = 1'b1;
    miss_pc    = 32'h0000_4ABC;
    tick();
    miss_valid    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = {$urandom, $urandom};
    tick();
    tick();
    mem_rsp_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({icachestop, mem_req_valid, refill_valid, byp_valid} !== 4'b0000)
      begin failures++; $display("FAIL async_rst_ctl: got %b want 0000", {icachestop, mem_req_valid, refill_valid, byp_valid}); end
    checks++;
    if ({mem_req_addr, refill_data} !== '0)
      begin failures++; $display("FAIL async_rst_data: got %h want 0", {mem_req_addr, refill_data}); end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (icachestop !== 1'b0)
      begin failures++; $display("FAIL post_rst_stop: got %b want 0", icachestop); end
    do_miss(32'h0000_4ABC, 0, 1, -1, 1'b0);
  endtask

  task automatic test_random();
    int fa;
    for (int n = 0; n < 16; n++) begin
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MEM_BEATS - 1)) : -1;
      do_miss($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), fa,
              1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush_in_fill();
    test_flush_in_req();
    test_flush_with_miss();
    test_bypass();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
